// File: rtl/ff_response_checker.sv
// Golden-model response checker for the SR/JK/D/T flip-flop block: compares DUT Q outputs
// against an internal lockstep model every cycle and keeps error counts and first-failure data.
module ff_response_checker #(
  parameter int unsigned CntW       = 16,
  parameter int unsigned Settle     = 1,
  parameter bit          StopOnFail = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            s_i,
  input  logic            r_i,
  input  logic            j_i,
  input  logic            k_i,
  input  logic            din_i,
  input  logic            t_i,
  input  logic            q_sr_i,
  input  logic            q_jk_i,
  input  logic            q_d_i,
  input  logic            q_t_i,
  output logic            err_o,
  output logic [3:0]      err_mask_o,
  output logic            pass_o,
  output logic [3:0]      first_mask_o,
  output logic [CntW-1:0] first_cycle_o,
  output logic [CntW-1:0] sample_cnt_o,
  output logic [CntW-1:0] err_cnt_o,
  output logic            sr_illegal_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSettle = 2'b01,
    StCheck  = 2'b10,
    StHalt   = 2'b11
  } state_e;

  localparam int unsigned SettleW = (Settle > 1) ? $clog2(Settle) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'((Settle == 0) ? 0 : Settle - 1);
  localparam logic [CntW-1:0] CntMax = '1;

  state_e              state_q, state_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [3:0]          mdl_q, mdl_d;        // [0]SR [1]JK [2]D [3]T
  logic                sr_valid_q, sr_valid_d;
  logic                err_q, err_d;
  logic [3:0]          err_mask_q, err_mask_d;
  logic                pass_q, pass_d;
  logic [3:0]          first_mask_q, first_mask_d;
  logic [CntW-1:0]     first_cycle_q, first_cycle_d;
  logic [CntW-1:0]     sample_cnt_q, sample_cnt_d;
  logic [CntW-1:0]     err_cnt_q, err_cnt_d;
  logic                sr_illegal_q, sr_illegal_d;
  logic [3:0]          mm;

  // SR compare is masked until a legal set/reset re-establishes a known value.
  always_comb begin
    mm[0] = (q_sr_i ^ mdl_q[0]) & sr_valid_q;
    mm[1] = q_jk_i ^ mdl_q[1];
    mm[2] = q_d_i ^ mdl_q[2];
    mm[3] = q_t_i ^ mdl_q[3];
  end

  always_comb begin
    mdl_d        = mdl_q;
    sr_valid_d   = sr_valid_q;
    sr_illegal_d = s_i & r_i;
    case ({s_i, r_i})
      2'b10: begin
        mdl_d[0]   = 1'b1;
        sr_valid_d = 1'b1;
      end
      2'b01: begin
        mdl_d[0]   = 1'b0;
        sr_valid_d = 1'b1;
      end
      2'b11: sr_valid_d = 1'b0;
      default: ;
    endcase
    case ({j_i, k_i})
      2'b10:   mdl_d[1] = 1'b1;
      2'b01:   mdl_d[1] = 1'b0;
      2'b11:   mdl_d[1] = ~mdl_q[1];
      default: ;
    endcase
    mdl_d[2] = din_i;
    mdl_d[3] = mdl_q[3] ^ t_i;
  end

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    err_d         = 1'b0;
    err_mask_d    = '0;
    pass_d        = pass_q;
    first_mask_d  = first_mask_q;
    first_cycle_d = first_cycle_q;
    sample_cnt_d  = sample_cnt_q;
    err_cnt_d     = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d  = (Settle == 0) ? StCheck : StSettle;
          settle_d = '0;
        end
      end
      StSettle: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (settle_q == SettleLast) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      StCheck: begin
        if (sample_cnt_q != CntMax) sample_cnt_d = sample_cnt_q + CntW'(1);
        err_d      = |mm;
        err_mask_d = mm;
        if (|mm) begin
          if (err_cnt_q != CntMax) err_cnt_d = err_cnt_q + CntW'(1);
          if (pass_q) begin
            pass_d        = 1'b0;
            first_mask_d  = mm;
            first_cycle_d = sample_cnt_q;
          end
        end
        if (StopOnFail && (|mm)) begin
          state_d = StHalt;
        end else if (!en_i) begin
          state_d = StIdle;
        end
      end
      StHalt: err_mask_d = err_mask_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      settle_q      <= '0;
      mdl_q         <= '0;
      sr_valid_q    <= 1'b1;
      err_q         <= 1'b0;
      err_mask_q    <= '0;
      pass_q        <= 1'b1;
      first_mask_q  <= '0;
      first_cycle_q <= '0;
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      sr_illegal_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      mdl_q         <= mdl_d;
      sr_valid_q    <= sr_valid_d;
      err_q         <= err_d;
      err_mask_q    <= err_mask_d;
      pass_q        <= pass_d;
      first_mask_q  <= first_mask_d;
      first_cycle_q <= first_cycle_d;
      sample_cnt_q  <= sample_cnt_d;
      err_cnt_q     <= err_cnt_d;
      sr_illegal_q  <= sr_illegal_d;
    end
  end

  assign err_o         = err_q;
  assign err_mask_o    = err_mask_q;
  assign pass_o        = pass_q;
  assign first_mask_o  = first_mask_q;
  assign first_cycle_o = first_cycle_q;
  assign sample_cnt_o  = sample_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign sr_illegal_o  = sr_illegal_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ff_response_checker.sv
// Bench for ff_response_checker: three parameterisations share one stimulus stream; a behavioural
// reference predicts every registered output and directed checks pin the key scenarios.
module tb_ff_response_checker;

  typedef struct packed {
    logic [1:0]  st;
    logic        err;
    logic [3:0]  mask;
    logic        pass;
    logic [3:0]  fmask;
    logic [15:0] fcyc;
    logic [15:0] scnt;
    logic [15:0] ecnt;
    logic        sri;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic [7:0] sc;
    logic [3:0] m;
    logic       srv;
  } mdl_t;

  typedef struct packed {
    obs_t a;
    obs_t h;
    obs_t n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, s_in, r_in, j_in, k_in, din_in, t_in;
  logic [3:0] q_vec;
  logic [3:0] ffq;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;
  exp_t exp_q[$];
  mdl_t m_a, m_h, m_n;

  logic        a_err, a_pass, a_sri, h_err, h_pass, h_sri, n_err, n_pass, n_sri;
  logic [3:0]  a_mask, a_fmask, h_mask, h_fmask, n_mask, n_fmask;
  logic [1:0]  a_st, h_st, n_st;
  logic [15:0] a_fcyc, a_scnt, a_ecnt, h_fcyc, h_scnt, h_ecnt;
  logic [3:0]  n_fcyc, n_scnt, n_ecnt;
  obs_t        obs_a, obs_h, obs_n;

  assign obs_a = {a_st, a_err, a_mask, a_pass, a_fmask, a_fcyc, a_scnt, a_ecnt, a_sri};
  assign obs_h = {h_st, h_err, h_mask, h_pass, h_fmask, h_fcyc, h_scnt, h_ecnt, h_sri};
  assign obs_n = {n_st, n_err, n_mask, n_pass, n_fmask, 12'd0, n_fcyc, 12'd0, n_scnt,
                  12'd0, n_ecnt, n_sri};

  ff_response_checker #(.CntW(16), .Settle(1), .StopOnFail(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .s_i(s_in), .r_i(r_in), .j_i(j_in), .k_i(k_in),
    .din_i(din_in), .t_i(t_in), .q_sr_i(q_vec[0]), .q_jk_i(q_vec[1]), .q_d_i(q_vec[2]),
    .q_t_i(q_vec[3]), .err_o(a_err), .err_mask_o(a_mask), .pass_o(a_pass),
    .first_mask_o(a_fmask), .first_cycle_o(a_fcyc), .sample_cnt_o(a_scnt),
    .err_cnt_o(a_ecnt), .sr_illegal_o(a_sri), .state_o(a_st)
  );

  ff_response_checker #(.CntW(16), .Settle(1), .StopOnFail(1'b1)) dut_h (
    .clk_i(clk), .rst_i(rst), .en_i(en), .s_i(s_in), .r_i(r_in), .j_i(j_in), .k_i(k_in),
    .din_i(din_in), .t_i(t_in), .q_sr_i(q_vec[0]), .q_jk_i(q_vec[1]), .q_d_i(q_vec[2]),
    .q_t_i(q_vec[3]), .err_o(h_err), .err_mask_o(h_mask), .pass_o(h_pass),
    .first_mask_o(h_fmask), .first_cycle_o(h_fcyc), .sample_cnt_o(h_scnt),
    .err_cnt_o(h_ecnt), .sr_illegal_o(h_sri), .state_o(h_st)
  );

  ff_response_checker #(.CntW(4), .Settle(0), .StopOnFail(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .en_i(en), .s_i(s_in), .r_i(r_in), .j_i(j_in), .k_i(k_in),
    .din_i(din_in), .t_i(t_in), .q_sr_i(q_vec[0]), .q_jk_i(q_vec[1]), .q_d_i(q_vec[2]),
    .q_t_i(q_vec[3]), .err_o(n_err), .err_mask_o(n_mask), .pass_o(n_pass),
    .first_mask_o(n_fmask), .first_cycle_o(n_fcyc), .sample_cnt_o(n_scnt),
    .err_cnt_o(n_ecnt), .sr_illegal_o(n_sri), .state_o(n_st)
  );

  // Ideal flip-flop block driving the Q lines (SR=11 holds).
  function automatic logic [3:0] ff_next(input logic [3:0] f, input logic rs,
                                         input logic [5:0] stim);
    logic [3:0] n;
    if (rs) return 4'b0000;
    n = f;
    if (stim[5] && !stim[4]) n[0] = 1'b1;
    else if (!stim[5] && stim[4]) n[0] = 1'b0;
    if (stim[3] && stim[2]) n[1] = ~f[1];
    else if (stim[3]) n[1] = 1'b1;
    else if (stim[2]) n[1] = 1'b0;
    n[2] = stim[1];
    n[3] = f[3] ^ stim[0];
    return n;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t c, input int cw, input int settle,
                                    input bit stop, input logic rs, input logic e,
                                    input logic [5:0] stim, input logic [3:0] q);
    mdl_t n;
    logic [3:0] mm;
    logic [15:0] mx;
    logic s, r;
    s  = stim[5];
    r  = stim[4];
    mx = 16'((32'd1 << cw) - 1);
    if (rs) begin
      n = '0;
      n.o.pass = 1'b1;
      n.srv = 1'b1;
      return n;
    end
    n = c;
    mm[0] = (q[0] != c.m[0]) && c.srv;
    mm[1] = q[1] != c.m[1];
    mm[2] = q[2] != c.m[2];
    mm[3] = q[3] != c.m[3];
    n.o.sri = s & r;
    n.m = ff_next(c.m, 1'b0, stim);
    if (s ^ r) n.srv = 1'b1;
    else if (s & r) n.srv = 1'b0;
    n.o.err = 1'b0;
    case (c.o.st)
      2'd0: begin
        n.o.mask = 4'd0;
        if (e) begin
          n.o.st = (settle == 0) ? 2'd2 : 2'd1;
          n.sc = 8'd0;
        end
      end
      2'd1: begin
        n.o.mask = 4'd0;
        if (!e) n.o.st = 2'd0;
        else if (int'(c.sc) == settle - 1) n.o.st = 2'd2;
        else n.sc = c.sc + 8'd1;
      end
      2'd2: begin
        if (c.o.scnt != mx) n.o.scnt = c.o.scnt + 16'd1;
        n.o.err = |mm;
        n.o.mask = mm;
        if (|mm) begin
          if (c.o.ecnt != mx) n.o.ecnt = c.o.ecnt + 16'd1;
          if (c.o.pass) begin
            n.o.pass = 1'b0;
            n.o.fmask = mm;
            n.o.fcyc = c.o.scnt;
          end
        end
        if (stop && (|mm)) n.o.st = 2'd3;
        else if (!e) n.o.st = 2'd0;
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [5:0] stim, input logic [3:0] cor);
    exp_t e;
    {s_in, r_in, j_in, k_in, din_in, t_in} = stim;
    q_vec = ffq ^ cor;
    m_a = mdl_next(m_a, 16, 1, 1'b0, rst, en, stim, q_vec);
    m_h = mdl_next(m_h, 16, 1, 1'b1, rst, en, stim, q_vec);
    m_n = mdl_next(m_n, 4, 0, 1'b0, rst, en, stim, q_vec);
    e.a = m_a.o;
    e.h = m_h.o;
    e.n = m_n.o;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ffq = ff_next(ffq, rst, stim);
    q_vec = ffq;
    if (exp_q.size() == 0) begin
      chk($sformatf("sb_empty%0d", step_no), 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("step%0d_a", step_no), 64'(obs_a), 64'(e.a));
      chk($sformatf("step%0d_h", step_no), 64'(obs_h), 64'(e.h));
      chk($sformatf("step%0d_n", step_no), 64'(obs_n), 64'(e.n));
    end
    step_no++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step(6'b000000, 4'b0000);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    {s_in, r_in, j_in, k_in, din_in, t_in} = 6'b0;
    ffq = 4'b0; q_vec = 4'b0;
    m_a = '0; m_h = '0; m_n = '0;

    // 1: clean run, stimulus order {S,R,J,K,Din,T}
    do_reset();
    chk("t1_rst_state", 64'(a_st), 64'd0);
    chk("t1_rst_pass", 64'(a_pass), 64'd1);
    en = 1'b1;
    step(6'b000000, 4'b0000);
    step(6'b101011, 4'b0000);
    step(6'b010100, 4'b0000);
    step(6'b001111, 4'b0000);
    chk("t1_state_a", 64'(a_st), 64'd2);
    chk("t1_scnt_a", 64'(a_scnt), 64'd2);
    chk("t1_scnt_n", 64'(n_scnt), 64'd3);
    chk("t1_pass_a", 64'(a_pass), 64'd1);
    chk("t1_ecnt_a", 64'(a_ecnt), 64'd0);

    // 2: Q_D wrong in the compare cycle with sample_cnt=2
    step(6'b100010, 4'b0100);
    chk("t2_err", 64'(a_err), 64'd1);
    chk("t2_mask", 64'(a_mask), 64'h4);
    chk("t2_fcyc", 64'(a_fcyc), 64'd2);
    chk("t2_fmask", 64'(a_fmask), 64'h4);
    chk("t2_ecnt", 64'(a_ecnt), 64'd1);
    chk("t2_pass", 64'(a_pass), 64'd0);
    step(6'b000001, 4'b0000);
    step(6'b000100, 4'b0000);
    chk("t2_pass_sticky", 64'(a_pass), 64'd0);
    chk("t2_err_pulse", 64'(a_err), 64'd0);

    // 3: S=R=1 masks SR until a legal set
    step(6'b110000, 4'b0000);
    chk("t3_sri", 64'(a_sri), 64'd1);
    step(6'b000000, 4'b0001);
    chk("t3_masked1", 64'(a_err), 64'd0);
    step(6'b000000, 4'b0001);
    chk("t3_masked2", 64'(a_err), 64'd0);
    chk("t3_sri_pulse", 64'(a_sri), 64'd0);
    step(6'b100000, 4'b0000);
    step(6'b000000, 4'b0001);
    chk("t3_sr_mask", 64'(a_mask), 64'h1);

    // 4: stop-on-fail halts on a JK toggle mismatch
    do_reset();
    en = 1'b1;
    step(6'b000000, 4'b0000);
    step(6'b000000, 4'b0000);
    step(6'b000000, 4'b0000);
    step(6'b001100, 4'b0000);
    step(6'b001100, 4'b0010);
    chk("t4_halt", 64'(h_st), 64'd3);
    chk("t4_herr", 64'(h_err), 64'd1);
    for (int i = 0; i < 10; i++) begin
      en = i[0];
      step(6'($urandom), 4'($urandom));
    end
    chk("t4_hscnt", 64'(h_scnt), 64'd3);
    chk("t4_hecnt", 64'(h_ecnt), 64'd1);
    chk("t4_hold", 64'(h_st), 64'd3);
    chk("t4_herr_low", 64'(h_err), 64'd0);
    do_reset();
    chk("t4_rst_state", 64'(h_st), 64'd0);
    chk("t4_rst_scnt", 64'(h_scnt), 64'd0);

    // 5: narrow counters saturate with Q_T forced wrong
    en = 1'b1;
    for (int i = 0; i < 21; i++) step(6'($urandom), 4'b1000);
    chk("t5_ecnt", 64'(n_ecnt), 64'd15);
    chk("t5_scnt", 64'(n_scnt), 64'd15);
    step(6'($urandom), 4'b0000);
    chk("t5_ecnt_sat", 64'(n_ecnt), 64'd15);

    // mixed traffic with sparse corruption and occasional en drops
    do_reset();
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 7) != 0);
      step(6'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000);
    end

    // 6: reset mid-CHECK
    do_reset();
    en = 1'b1;
    step(6'b000000, 4'b0000);
    step(6'b000000, 4'b0000);
    for (int i = 0; i < 3; i++) step(6'b000000, 4'b0100);
    chk("t6_ecnt3", 64'(a_ecnt), 64'd3);
    rst = 1'b1;
    step(6'b101011, 4'b0000);
    rst = 1'b0;
    chk("t6_ecnt0", 64'(a_ecnt), 64'd0);
    chk("t6_pass", 64'(a_pass), 64'd1);
    chk("t6_state", 64'(a_st), 64'd0);
    step(6'b000000, 4'b0000);
    step(6'b000000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
